// File: rtl/mul_pkg.sv
// Shared constants and FSM encoding for the seq_mul scheduler.
package mul_pkg;
  localparam int MUL_LAT_DEF = 9;
  localparam int OP_W        = 8;
  localparam int PROD_W      = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;
endpackage

// File: rtl/rr_arb2.sv
// Two-request round-robin arbiter; ptr names the requester that wins a tie.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt,
  output logic       ptr
);
  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = ptr ? 2'b10 : 2'b01;
  end

  // After a grant the pointer moves to the other requester, even for a lone winner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr <= 1'b0;
    else if (advance && (gnt != 2'b00)) ptr <= gnt[0];
  end
endmodule

// File: rtl/mul_sched.sv
// Shares one seq_mul core between two requesters and returns tagged products
// after a fixed latency, since the core has no done flag.
module mul_sched
  import mul_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int CNT_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic [OP_W-1:0]   req0_a,
  input  logic [OP_W-1:0]   req0_b,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [OP_W-1:0]   req1_a,
  input  logic [OP_W-1:0]   req1_b,
  output logic              req1_ready,
  output logic              rsp_valid,
  output logic              rsp_id,
  output logic [PROD_W-1:0] rsp_data,
  input  logic              rsp_ready,
  output logic              mul_start,
  output logic [OP_W-1:0]   mul_a,
  output logic [OP_W-1:0]   mul_b,
  input  logic [PROD_W-1:0] mul_op,
  output logic              busy
);
  // Handshakes: a request moves when reqN_valid && reqN_ready at a rising edge;
  // a response moves when rsp_valid && rsp_ready; valid never waits on ready.
  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       gnt;
  logic             arb_ptr;
  logic             accept;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     ({req1_valid, req0_valid}),
    .advance (accept),
    .gnt     (gnt),
    .ptr     (arb_ptr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = START;
      START:   state_nx = RUN;
      RUN:     if (cnt == '0) state_nx = DONE;
      DONE:    if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    accept     = 1'b0;
    if (rst_n && (state == IDLE)) begin
      req0_ready = gnt[0];
      req1_ready = gnt[1];
      accept     = |gnt;
    end
  end

  // Strobes are registered off the next state so they line up with the state itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_start <= 1'b0;
      rsp_valid <= 1'b0;
      busy      <= 1'b0;
      mul_a     <= '0;
      mul_b     <= '0;
      rsp_id    <= 1'b0;
      rsp_data  <= '0;
      cnt       <= '0;
    end else begin
      mul_start <= (state_nx == START);
      rsp_valid <= (state_nx == DONE);
      busy      <= (state_nx != IDLE);
      if (accept) begin
        mul_a  <= gnt[1] ? req1_a : req0_a;
        mul_b  <= gnt[1] ? req1_b : req0_b;
        rsp_id <= gnt[1];
      end
      if (state == START) begin
        cnt <= CNT_W'(MUL_LAT - 1);
      end else if (state == RUN) begin
        cnt <= cnt - CNT_W'(1);
        if (cnt == '0) rsp_data <= mul_op;
      end
    end
  end

  // While a job runs, the pointer has already moved off the requester it belongs to.
  ptr_off_winner: assert property (@(posedge clk) disable iff (!rst_n)
    (state == RUN) |-> (arb_ptr != rsp_id));
endmodule
